// File: rtl/tone_synth_if.sv
// tone_synth_if: control and audio signals of the tone synthesizer.
// The master side (controller or testbench) drives the tone request.
// The slave side (tone_synth) returns the audio output and status.
interface tone_synth_if #(
  parameter int OCT_W = 2
);
  logic             en;
  logic [2:0]       note;
  logic [OCT_W-1:0] octave;
  logic             load;
  logic             auto;
  logic             tone_out;
  logic [2:0]       cur_note;
  logic             period_tick;

  modport master (
    output en, note, octave, load, auto,
    input  tone_out, cur_note, period_tick
  );

  modport slave (
    input  en, note, octave, load, auto,
    output tone_out, cur_note, period_tick
  );
endinterface

// File: rtl/tone_synth.sv
// tone_synth: square-wave tone generator for an 8-note scale with octave shift.
// The half period is D[note] >> octave clocks, with a floor of 1.
// Note and octave changes are queued in a pending register. They take effect
// only at a full-period boundary (the 1->0 edge of tone_out), so the waveform
// is never cut short. When the tone is disabled, a queued change applies at once.
// Optional feature: define TONE_SYNTH_AUTOPLAY_EN to build autoplay. With
// autoplay, the note advances by one every STEP_PERIODS periods while auto=1.
module tone_synth #(
  parameter int DIV_W        = 16,
  parameter int OCT_W        = 2,
  parameter int STEP_PERIODS = 4
) (
  input logic         clk,
  input logic         reset,
  tone_synth_if.slave bus
);

  // Half-period clock counts at 50 MHz for do..do2.
  function automatic logic [DIV_W-1:0] div_lookup(input logic [2:0] n);
    case (n)
      3'd0:    return DIV_W'(47801);
      3'd1:    return DIV_W'(42590);
      3'd2:    return DIV_W'(37937);
      3'd3:    return DIV_W'(35817);
      3'd4:    return DIV_W'(31929);
      3'd5:    return DIV_W'(28409);
      3'd6:    return DIV_W'(25330);
      default: return DIV_W'(23901);
    endcase
  endfunction

  logic [DIV_W-1:0] r_cnt;
  logic             r_tone;
  logic             r_tick;
  logic [2:0]       r_cur_note;
  logic [OCT_W-1:0] r_cur_oct;
  logic             r_pend;
  logic [2:0]       r_pend_note;
  logic [OCT_W-1:0] r_pend_oct;

`ifdef TONE_SYNTH_AUTOPLAY_EN
  localparam int STEP_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  logic [STEP_W-1:0] r_step;
`endif

  logic [DIV_W-1:0] w_shift;
  logic [DIV_W-1:0] w_half;
  logic             w_last;
  logic             w_bnd;
  logic             w_apply;

  // A very high octave can shift the divisor down to zero, so clamp it to 1.
  assign w_shift = div_lookup(r_cur_note) >> r_cur_oct;
  assign w_half  = (w_shift == '0) ? DIV_W'(1) : w_shift;
  assign w_last  = (r_cnt == (w_half - DIV_W'(1)));
  // A boundary is the toggle that takes tone_out from 1 to 0.
  assign w_bnd   = bus.en && w_last && r_tone;
  // A queued change lands at a boundary, or at once while the tone is off.
  assign w_apply = r_pend && (w_bnd || !bus.en);

  // Half-period counter, square-wave output and period tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_tone <= 1'b0;
      r_tick <= 1'b0;
    end else if (!bus.en) begin
      r_cnt  <= '0;
      r_tone <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_bnd;
      if (w_last) begin
        r_cnt  <= '0;
        r_tone <= ~r_tone;
      end else begin
        r_cnt  <= r_cnt + DIV_W'(1);
      end
    end
  end

  // Pending note queue, current note/octave and optional autoplay stepping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cur_note  <= 3'd0;
      r_cur_oct   <= '0;
      r_pend      <= 1'b0;
      r_pend_note <= 3'd0;
      r_pend_oct  <= '0;
`ifdef TONE_SYNTH_AUTOPLAY_EN
      r_step      <= '0;
`endif
    end else begin
      if (w_apply) begin
        r_cur_note <= r_pend_note;
        r_cur_oct  <= r_pend_oct;
      end
      // A load in the same cycle as a boundary is queued for the next boundary.
      if (bus.load) begin
        r_pend_note <= bus.note;
        r_pend_oct  <= bus.octave;
        r_pend      <= 1'b1;
      end else if (w_apply) begin
        r_pend      <= 1'b0;
      end
`ifdef TONE_SYNTH_AUTOPLAY_EN
      // Explicit loads win over autoplay and restart the step count.
      if (w_apply || bus.load || !bus.auto) begin
        r_step <= '0;
      end else if (w_bnd) begin
        if (r_step == STEP_W'(STEP_PERIODS - 1)) begin
          r_step     <= '0;
          r_cur_note <= r_cur_note + 3'd1;
        end else begin
          r_step     <= r_step + STEP_W'(1);
        end
      end
`endif
    end
  end

  assign bus.tone_out    = r_tone;
  assign bus.cur_note    = r_cur_note;
  assign bus.period_tick = r_tick;

endmodule
